// File: rtl/riscv_core_dcache_store_fifo.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_dcache_store_fifo
// Brief    : Write-through store FIFO draining as single-beat AXI writes.
//            RAW hazard check enabled by RISCV_DCACHE_STORE_FIFO_RAW_CHECK_EN.
// Revision : 1.0
// ============================================================================
module riscv_core_dcache_store_fifo #(
  parameter int DEPTH            = 4,
  parameter int ADDR_WIDTH       = 64,
  parameter int CORE_DATA_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH   = 256,
  parameter int FIFO_ENTRY_WIDTH = 128
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [CORE_DATA_WIDTH-1:0]  i_data,
  input  logic [1:0]                  i_size,
  output logic                        o_full,
  output logic                        o_empty,
  input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
  output logic                        o_raw_hazard,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [ADDR_WIDTH-1:0]       o_awaddr,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  input  logic                        i_bvalid,
  input  logic [1:0]                  i_bresp,
  output logic                        o_bready,
  output logic                        o_bus_err
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_STRB_W = AXI_DATA_WIDTH / 8;
  localparam int c_OFF_W  = $clog2(c_STRB_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [FIFO_ENTRY_WIDTH-1:0] r_mem  [DEPTH];
  logic [1:0]                  r_size [DEPTH];
  logic [c_PTR_W-1:0]          r_wr_ptr;
  logic [c_PTR_W-1:0]          r_rd_ptr;
  logic [c_CNT_W-1:0]          r_count;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_bus_err;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic [ADDR_WIDTH-1:0]       w_head_addr;
  logic [CORE_DATA_WIDTH-1:0]  w_head_data;
  logic [AXI_DATA_WIDTH-1:0]   w_data_ext;
  logic [7:0]                  w_mask;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = (r_state == ST_RESP) && i_bvalid;
  assign w_aw_hs   = (r_state == ST_SEND) && !r_aw_done && i_awready;
  assign w_w_hs    = (r_state == ST_SEND) && !r_w_done && i_wready;
  assign o_bus_err = r_bus_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_size[i] <= 2'b00;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr]  <= FIFO_ENTRY_WIDTH'({i_addr, i_data});
      r_size[r_wr_ptr] <= i_size;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_err <= w_pop && (i_bresp != 2'b00);
      if (r_state == ST_IDLE) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!o_empty) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        o_awvalid = !r_aw_done;
        o_wvalid  = !r_w_done;
        // Either channel may finish first; a same-cycle handshake counts.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_head_addr = r_mem[r_rd_ptr][CORE_DATA_WIDTH +: ADDR_WIDTH];
  assign w_head_data = r_mem[r_rd_ptr][0 +: CORE_DATA_WIDTH];

  always_comb begin
    case (r_size[r_rd_ptr])
      2'b00:   w_mask = 8'h01;
      2'b01:   w_mask = 8'h03;
      2'b10:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_data_ext = AXI_DATA_WIDTH'(w_head_data);
  assign o_awaddr   = {w_head_addr[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
  assign o_wdata    = w_data_ext << {w_head_addr[c_OFF_W-1:0], 3'b000};
  // Reset-state head has size 0 (byte mask), so gate strobes while empty.
  assign o_wstrb    = o_empty ? '0 : (c_STRB_W'(w_mask) << w_head_addr[c_OFF_W-1:0]);

`ifdef RISCV_DCACHE_STORE_FIFO_RAW_CHECK_EN
  logic [DEPTH-1:0] w_hit;
  logic [2:0]       w_unused_rd_lsb;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_raw
    logic [c_PTR_W-1:0] w_off;
    assign w_off     = c_PTR_W'(gi) - r_rd_ptr;
    assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                       (r_mem[gi][CORE_DATA_WIDTH+3 +: ADDR_WIDTH-3] == i_rd_addr[ADDR_WIDTH-1:3]);
  end

  assign o_raw_hazard    = |w_hit;
  assign w_unused_rd_lsb = i_rd_addr[2:0];
`else
  logic [ADDR_WIDTH-1:0] w_unused_rd_addr;
  assign o_raw_hazard     = 1'b0;
  assign w_unused_rd_addr = i_rd_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_dcache_store_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_dcache_store_fifo
// Brief    : Scoreboard bench with randomized AXI handshakes and a queue model.
// Revision : 1.0
// ============================================================================
module tb_riscv_core_dcache_store_fifo;

  localparam int DEPTH = 4;
`ifdef RISCV_DCACHE_STORE_FIFO_RAW_CHECK_EN
  localparam bit c_RAW_EN = 1'b1;
`else
  localparam bit c_RAW_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_push;
  logic [63:0]  i_addr;
  logic [63:0]  i_data;
  logic [1:0]   i_size;
  logic         o_full, o_empty;
  logic [63:0]  i_rd_addr;
  logic         o_raw_hazard;
  logic         o_awvalid, i_awready;
  logic [63:0]  o_awaddr;
  logic         o_wvalid, i_wready;
  logic [255:0] o_wdata;
  logic [31:0]  o_wstrb;
  logic         i_bvalid;
  logic [1:0]   i_bresp;
  logic         o_bready, o_bus_err;

  riscv_core_dcache_store_fifo dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(i_push), .i_addr(i_addr), .i_data(i_data),
    .i_size(i_size), .o_full(o_full), .o_empty(o_empty), .i_rd_addr(i_rd_addr),
    .o_raw_hazard(o_raw_hazard), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_awaddr(o_awaddr), .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } st_t;

  st_t q[$];
  int  total = 0;
  int  bad   = 0;

  // 0 = random, 1 = always ready, 2 = never ready
  int       aw_mode = 2, w_mode = 2, b_mode = 2;
  bit       bresp_rand = 1'b0;
  logic [1:0] bresp_force = 2'b00;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] exp_wdata(input st_t s);
    logic [255:0] r = '0;
    int off = int'(s.addr[4:0]);
    for (int b = 0; b < 8; b++)
      if (off + b < 32) r[(off+b)*8 +: 8] = s.data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_wstrb(input st_t s);
    logic [31:0] r = '0;
    int off = int'(s.addr[4:0]);
    int n   = 1 << s.size;
    for (int b = 0; b < n; b++)
      if (off + b < 32) r[off+b] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    i_push = 1'b1; i_addr = a; i_data = d; i_size = s;
    step();
    i_push = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    for (int k = 0; k < max && !(o_empty && q.size() == 0); k++) step();
    chk("drain_done", o_empty, 1'b1);
  endtask

  // AXI slave response driver
  initial begin
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      i_awready = (aw_mode == 1) ? 1'b1 : (aw_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      i_wready  = (w_mode == 1)  ? 1'b1 : (w_mode == 2)  ? 1'b0 : 1'($urandom_range(0, 1));
      i_bvalid  = o_bready && ((b_mode == 1) || (b_mode == 0 && $urandom_range(0, 1) == 1));
      if (bresp_rand) i_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else            i_bresp = bresp_force;
    end
  end

  // Monitor / scoreboard
  bit awd, wd, prev_aw, prev_w, pend_berr;
  always @(negedge clk) begin
    int  sz;
    bit  exp_raw, pop, push_ok;
    if (!rst_n) begin
      q.delete();
      awd = 0; wd = 0; prev_aw = 0; prev_w = 0; pend_berr = 0;
    end else begin
      sz = q.size();
      chk("empty", o_empty, sz == 0);
      chk("full", o_full, sz == DEPTH);
      exp_raw = 1'b0;
      if (c_RAW_EN)
        foreach (q[i]) if (q[i].addr[63:3] == i_rd_addr[63:3]) exp_raw = 1'b1;
      chk("raw_hazard", o_raw_hazard, exp_raw);
      chk("bus_err", o_bus_err, pend_berr);
      if (prev_aw) chk("awvalid_hold", o_awvalid, 1'b1);
      if (prev_w)  chk("wvalid_hold", o_wvalid, 1'b1);
      if (awd) chk("awvalid_after_done", o_awvalid, 1'b0);
      if (wd)  chk("wvalid_after_done", o_wvalid, 1'b0);
      if (o_awvalid) begin
        if (sz == 0) chk("awvalid_no_entry", o_awvalid, 1'b0);
        else         chk("awaddr", o_awaddr, q[0].addr & ~64'h1f);
      end
      if (o_wvalid) begin
        if (sz == 0) chk("wvalid_no_entry", o_wvalid, 1'b0);
        else begin
          chk("wdata", o_wdata, exp_wdata(q[0]));
          chk("wstrb", o_wstrb, exp_wstrb(q[0]));
        end
      end
      if (o_bready) chk("bready_before_aw_w", {awd, wd}, 2'b11);
      prev_aw = o_awvalid && !i_awready;
      prev_w  = o_wvalid && !i_wready;
      if (o_awvalid && i_awready) awd = 1'b1;
      if (o_wvalid && i_wready)   wd  = 1'b1;
      pop       = o_bready && i_bvalid;
      pend_berr = pop && (i_bresp != 2'b00);
      push_ok   = i_push && (sz < DEPTH);
      if (pop) begin
        if (sz > 0) void'(q.pop_front());
        awd = 1'b0; wd = 1'b0;
      end
      if (push_ok) q.push_back('{addr: i_addr, data: i_data, size: i_size});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; i_push = 1'b0; i_addr = '0; i_data = '0; i_size = 2'b00; i_rd_addr = '0;
    repeat (3) step();
    chk("rst_awvalid", o_awvalid, 1'b0);
    chk("rst_wvalid", o_wvalid, 1'b0);
    chk("rst_bready", o_bready, 1'b0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_full", o_full, 1'b0);
    chk("rst_raw", o_raw_hazard, 1'b0);
    chk("rst_bus_err", o_bus_err, 1'b0);
    chk("rst_awaddr", o_awaddr, 64'h0);
    chk("rst_wdata", o_wdata, 256'h0);
    chk("rst_wstrb", o_wstrb, 32'h0);
    rst_n = 1'b1;
    step();

    // Byte store at 0x1003, channels stalled
    aw_mode = 2; w_mode = 2; b_mode = 1;
    step();
    push(64'h1003, 64'hAB, 2'b00);
    chk("t1_empty_fell", o_empty, 1'b0);
    chk("t1_awvalid_not_yet", o_awvalid, 1'b0);
    step();
    chk("t1_awvalid", o_awvalid, 1'b1);
    chk("t1_awaddr", o_awaddr, 64'h1000);
    chk("t1_wstrb", o_wstrb, 32'h0000_0008);
    chk("t1_wdata_b3", o_wdata[31:24], 8'hAB);
    aw_mode = 1; w_mode = 1;
    wait_empty(50);

    // Dword at 0x2018 with immediate ready: pop 3 cycles after push edge
    repeat (2) step();
    push(64'h2018, 64'h1122334455667788, 2'b11);
    step();
    chk("t2_wstrb", o_wstrb, 32'hFF00_0000);
    k = 1;
    while (!o_empty && k < 20) begin
      step();
      k++;
    end
    chk("t2_pop_latency", k, 3);

    // Fill to DEPTH twice (second pass wraps the pointers)
    for (int rep = 0; rep < 2; rep++) begin
      aw_mode = 2; w_mode = 2;
      repeat (2) step();
      for (int i = 0; i < DEPTH; i++)
        push(64'h5000 + 64'(rep*256 + i*8), 64'(32'hC0DE0000 + rep*16 + i), 2'b11);
      chk("fill_full", o_full, 1'b1);
      push(64'h9000, 64'hDEAD, 2'b11);
      chk("fill_full_after_drop", o_full, 1'b1);
      aw_mode = 1; w_mode = 1;
      wait_empty(100);
    end

    // W ready long before AW
    aw_mode = 2; w_mode = 1; b_mode = 1;
    repeat (2) step();
    push(64'h6020, 64'h1234_5678, 2'b10);
    repeat (3) step();
    chk("t4_wvalid_dropped", o_wvalid, 1'b0);
    chk("t4_awvalid_held", o_awvalid, 1'b1);
    chk("t4_no_resp", o_bready, 1'b0);
    aw_mode = 1;
    wait_empty(50);

    // SLVERR response
    bresp_force = 2'b10;
    repeat (2) step();
    push(64'h40, 64'hCAFE_F00D, 2'b10);
    wait_empty(50);
    chk("t5_bus_err_pulse", o_bus_err, 1'b1);
    step();
    chk("t5_bus_err_low", o_bus_err, 1'b0);
    bresp_force = 2'b00;

    // RAW hazard
    aw_mode = 2; w_mode = 2;
    repeat (2) step();
    push(64'h3010, 64'h77, 2'b10);
    i_rd_addr = 64'h3014;
    #1;
    chk("t6_raw_hit", o_raw_hazard, c_RAW_EN);
    i_rd_addr = 64'h3018;
    #1;
    chk("t6_raw_miss", o_raw_hazard, 1'b0);
    i_rd_addr = 64'h3010;
    aw_mode = 1; w_mode = 1;
    wait_empty(50);
    chk("t6_raw_after_pop", o_raw_hazard, 1'b0);

    // Randomized traffic
    aw_mode = 0; w_mode = 0; b_mode = 0; bresp_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic [1:0]  s;
      logic [63:0] a;
      s = 2'($urandom_range(0, 3));
      a = (64'h3000 + 64'($urandom_range(0, 255))) & ~((64'd1 << s) - 64'd1);
      i_push    = ($urandom_range(0, 2) == 0);
      i_addr    = a;
      i_data    = {32'($urandom), 32'($urandom)};
      i_size    = s;
      i_rd_addr = 64'h3000 + 64'($urandom_range(0, 255));
      step();
    end
    i_push = 1'b0;
    aw_mode = 1; w_mode = 1; b_mode = 1;
    wait_empty(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
